// File: rtl/rvecc_pipe.sv
// Pipelined SECDED check/correct stage with valid/ready handshake, saturating error counters and a sticky error log.
// RV_ECC_PIPE_DUAL_STAGE_EN selects two register stages; undefined gives a single stage with combinational correction.
module rvecc_pipe #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned P    = (DW <= 11) ? 4 : (DW <= 26) ? 5 : (DW <= 57) ? 6 : 7,
    localparam int unsigned EW   = P + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [EW-1:0]    in_ecc,
    input  logic             in_sed_ded,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [EW-1:0]    out_ecc,
    output logic             out_sb_err,
    output logic             out_db_err,
    output logic [CNT_W-1:0] sb_cnt,
    output logic [CNT_W-1:0] db_cnt,
    input  logic             cnt_clr,
    output logic             log_valid,
    output logic [EW-1:0]    log_syndrome,
    output logic [DW-1:0]    log_data,
    input  logic             log_clr
);

    // Hamming position of data bit idx: the idx-th non-power-of-two position starting at 3.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n   = 0;
        int unsigned res = 0;
        for (int unsigned pos = 3; pos < 256; pos++) begin
            if ((pos & (pos - 32'd1)) != 32'd0) begin
                if (n == idx) res = pos;
                n++;
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] chk_mask(input int unsigned k);
        logic [DW-1:0] m = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            m[i] = ((data_pos(i) >> k) & 32'd1) != 32'd0;
        end
        return m;
    endfunction

    logic [P-1:0]  in_chk;
    logic [EW-1:0] in_syn;

    for (genvar k = 0; k < P; k++) begin : g_chk
        localparam logic [DW-1:0] MASK = chk_mask(k);
        assign in_chk[k] = ^(in_data & MASK);
    end

    assign in_syn[P-1:0] = in_chk ^ in_ecc[P-1:0];
    assign in_syn[EW-1]  = ~in_sed_ded & ((^in_data) ^ (^in_ecc));

    logic          s1_v, s1_adv, s1_sed;
    logic [DW-1:0] s1_data;
    logic [EW-1:0] s1_ecc, s1_syn;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_v    <= 1'b0;
            s1_sed  <= 1'b0;
            s1_data <= '0;
            s1_ecc  <= '0;
            s1_syn  <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_sed  <= in_sed_ded;
                s1_data <= in_data;
                s1_ecc  <= in_ecc;
                s1_syn  <= in_syn;
            end
        end
    end

    // Classify and correct from the S1 registers.
    logic [P-1:0]  s1_pos;
    logic          c_sb, c_db;
    logic [DW-1:0] d_flip, c_data;
    logic [EW-1:0] e_flip, c_ecc;

    assign s1_pos = s1_syn[P-1:0];

    always_comb begin
        c_sb = 1'b0;
        c_db = 1'b0;
        if (s1_syn != '0) begin
            if (s1_syn[EW-1] && !s1_sed && (32'(s1_pos) <= DW + P)) c_sb = 1'b1;
            else                                                    c_db = 1'b1;
        end
    end

    for (genvar i = 0; i < DW; i++) begin : g_dflip
        localparam int unsigned POS = data_pos(i);
        assign d_flip[i] = c_sb & (32'(s1_pos) == POS);
    end

    for (genvar k = 0; k < P; k++) begin : g_eflip
        assign e_flip[k] = c_sb & (32'(s1_pos) == (32'd1 << k));
    end

    assign e_flip[EW-1] = c_sb & (s1_pos == '0);
    assign c_data       = s1_data ^ d_flip;
    assign c_ecc        = s1_ecc ^ e_flip;

    logic [DW-1:0] out_raw;
    logic [EW-1:0] out_syn;

`ifdef RV_ECC_PIPE_DUAL_STAGE_EN
    logic          s2_v, s2_adv, s2_sb, s2_db;
    logic [DW-1:0] s2_data, s2_raw;
    logic [EW-1:0] s2_ecc, s2_syn;

    assign s2_adv = ~s2_v | out_ready;
    assign s1_adv = ~s1_v | s2_adv;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s2_v    <= 1'b0;
            s2_sb   <= 1'b0;
            s2_db   <= 1'b0;
            s2_data <= '0;
            s2_raw  <= '0;
            s2_ecc  <= '0;
            s2_syn  <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_sb   <= c_sb;
                s2_db   <= c_db;
                s2_data <= c_data;
                s2_raw  <= s1_data;
                s2_ecc  <= c_ecc;
                s2_syn  <= s1_syn;
            end
        end
    end

    assign out_valid  = s2_v;
    assign out_data   = s2_data;
    assign out_ecc    = s2_ecc;
    assign out_sb_err = s2_sb;
    assign out_db_err = s2_db;
    assign out_raw    = s2_raw;
    assign out_syn    = s2_syn;
`else
    assign s1_adv     = ~s1_v | out_ready;
    assign out_valid  = s1_v;
    assign out_data   = c_data;
    assign out_ecc    = c_ecc;
    assign out_sb_err = c_sb;
    assign out_db_err = c_db;
    assign out_raw    = s1_data;
    assign out_syn    = s1_syn;
`endif

    assign in_ready = s1_adv;

    logic hs;
    assign hs = out_valid & out_ready;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sb_cnt <= '0;
            db_cnt <= '0;
        end else if (cnt_clr) begin
            sb_cnt <= '0;
            db_cnt <= '0;
        end else begin
            if (hs && out_sb_err && (sb_cnt != '1)) sb_cnt <= sb_cnt + CNT_W'(1);
            if (hs && out_db_err && (db_cnt != '1)) db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Sticky log: first error, or a db replacing a logged sb; log_clr re-arms it.
    logic log_db;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            log_valid    <= 1'b0;
            log_db       <= 1'b0;
            log_syndrome <= '0;
            log_data     <= '0;
        end else if (hs && (out_sb_err || out_db_err) &&
                     (!log_valid || log_clr || (out_db_err && !log_db))) begin
            log_valid    <= 1'b1;
            log_db       <= out_db_err;
            log_syndrome <= out_syn;
            log_data     <= out_raw;
        end else if (log_clr) begin
            log_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvecc_pipe.sv
// Directed bench for rvecc_pipe (DW=32, CNT_W=2); follows RV_ECC_PIPE_DUAL_STAGE_EN for latency and buffering.
module tb_rvecc_pipe;
`ifdef RV_ECC_PIPE_DUAL_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk, rst_l;
    logic        in_valid, in_ready, in_sed_ded;
    logic [31:0] in_data;
    logic [6:0]  in_ecc;
    logic        out_valid, out_ready, out_sb_err, out_db_err;
    logic [31:0] out_data;
    logic [6:0]  out_ecc;
    logic [1:0]  sb_cnt, db_cnt;
    logic        cnt_clr, log_valid, log_clr;
    logic [6:0]  log_syndrome;
    logic [31:0] log_data;

    rvecc_pipe #(.DW(32), .CNT_W(2)) dut (
        .clk(clk), .rst_l(rst_l),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ecc(in_ecc), .in_sed_ded(in_sed_ded),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ecc(out_ecc), .out_sb_err(out_sb_err), .out_db_err(out_db_err),
        .sb_cnt(sb_cnt), .db_cnt(db_cnt), .cnt_clr(cnt_clr),
        .log_valid(log_valid), .log_syndrome(log_syndrome), .log_data(log_data),
        .log_clr(log_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] r_data;
    logic [6:0]  r_ecc;
    logic        r_sb, r_db;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one word with out_ready high, check latency, capture outputs, complete the handshake.
    task automatic xfer(input logic [31:0] d, input logic [6:0] e, input logic sed,
                        input logic clr, input logic lclr);
        int n;
        @(negedge clk);
        out_ready = 1'b1; in_data = d; in_ecc = e; in_sed_ded = sed; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT - 1));
        r_data = out_data; r_ecc = out_ecc; r_sb = out_sb_err; r_db = out_db_err;
        cnt_clr = clr; log_clr = lclr;
        @(posedge clk); #1;
        cnt_clr = 1'b0; log_clr = 1'b0;
    endtask

    logic [31:0] wq [3];
    logic [31:0] got [$];
    int          acc;
    logic        take;

    initial begin
        rst_l = 1'b0; in_valid = 1'b0; in_data = '0; in_ecc = '0; in_sed_ded = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0; log_clr = 1'b0;
        wq[0] = 32'h3; wq[1] = 32'h30; wq[2] = 32'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_sb_cnt", 64'(sb_cnt), 64'h0);
        chk("rst_db_cnt", 64'(db_cnt), 64'h0);
        chk("rst_log_valid", 64'(log_valid), 64'h0);
        @(negedge clk); rst_l = 1'b1;

        // clean word
        xfer(32'h0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("clean_data", 64'(r_data), 64'h0);
        chk("clean_ecc", 64'(r_ecc), 64'h0);
        chk("clean_sb", 64'(r_sb), 64'h0);
        chk("clean_db", 64'(r_db), 64'h0);
        chk("clean_sb_cnt", 64'(sb_cnt), 64'h0);
        chk("clean_db_cnt", 64'(db_cnt), 64'h0);
        chk("clean_log", 64'(log_valid), 64'h0);

        // d5 flipped: syndrome 0x4A
        xfer(32'h20, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("sb_data", 64'(r_data), 64'h0);
        chk("sb_flag", 64'(r_sb), 64'h1);
        chk("sb_db", 64'(r_db), 64'h0);
        chk("sb_cnt1", 64'(sb_cnt), 64'h1);
        chk("sb_log_valid", 64'(log_valid), 64'h1);
        chk("sb_log_syn", 64'(log_syndrome), 64'h4A);
        chk("sb_log_data", 64'(log_data), 64'h20);

        // check bit 2 flipped; log keeps first sb
        xfer(32'h0, 7'h04, 1'b0, 1'b0, 1'b0);
        chk("cb_ecc", 64'(r_ecc), 64'h0);
        chk("cb_sb", 64'(r_sb), 64'h1);
        chk("cb_cnt2", 64'(sb_cnt), 64'h2);
        chk("cb_log_syn", 64'(log_syndrome), 64'h4A);

        // overall parity bit only flipped
        xfer(32'h0, 7'h40, 1'b0, 1'b0, 1'b0);
        chk("op_ecc", 64'(r_ecc), 64'h0);
        chk("op_sb", 64'(r_sb), 64'h1);
        chk("op_cnt3", 64'(sb_cnt), 64'h3);

        // double error upgrades log
        xfer(32'h3, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("db_flag", 64'(r_db), 64'h1);
        chk("db_sb", 64'(r_sb), 64'h0);
        chk("db_data", 64'(r_data), 64'h3);
        chk("db_cnt1", 64'(db_cnt), 64'h1);
        chk("db_log_syn", 64'(log_syndrome), 64'h06);
        chk("db_log_data", 64'(log_data), 64'h3);

        // second db leaves log alone
        xfer(32'h30, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("db2_flag", 64'(r_db), 64'h1);
        chk("db2_log_syn", 64'(log_syndrome), 64'h06);
        chk("db2_cnt", 64'(db_cnt), 64'h2);

        // sed_ded mode: single flip reported db, not corrected
        xfer(32'h20, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("sed_db", 64'(r_db), 64'h1);
        chk("sed_sb", 64'(r_sb), 64'h0);
        chk("sed_data", 64'(r_data), 64'h20);
        chk("sed_cnt", 64'(db_cnt), 64'h3);

        // saturation: sb words four and five, one more db
        xfer(32'h20, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("sat_sb4", 64'(sb_cnt), 64'h3);
        xfer(32'h20, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("sat_sb5", 64'(sb_cnt), 64'h3);
        xfer(32'h3, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("sat_db", 64'(db_cnt), 64'h3);

        // cnt_clr with a sixth sb word
        xfer(32'h20, 7'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_sb_cnt", 64'(sb_cnt), 64'h0);
        chk("clr_db_cnt", 64'(db_cnt), 64'h0);

        // log_clr with an erroring handshake recaptures
        xfer(32'h20, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("lclr_valid", 64'(log_valid), 64'h1);
        chk("lclr_syn", 64'(log_syndrome), 64'h4A);
        chk("lclr_data", 64'(log_data), 64'h20);
        chk("lclr_sb_cnt", 64'(sb_cnt), 64'h1);

        // log_clr with a clean word empties the log
        xfer(32'h0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("lclr_empty", 64'(log_valid), 64'h0);

        // syndrome position 40 is beyond the codeword
        xfer(32'h0, 7'h68, 1'b0, 1'b0, 1'b0);
        chk("oor_db", 64'(r_db), 64'h1);
        chk("oor_sb", 64'(r_sb), 64'h0);
        chk("oor_ecc", 64'(r_ecc), 64'h68);
        chk("oor_log_syn", 64'(log_syndrome), 64'h68);
        chk("oor_db_cnt", 64'(db_cnt), 64'h1);

        // backpressure: A, B, C with out_ready low for 4 cycles
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_ecc = '0; in_sed_ded = 1'b0;
            in_valid = (acc < 3);
            if (acc < 3) in_data = wq[acc];
            #1;
            if (c == LAT) chk("bp_in_ready_low", 64'(in_ready), 64'h0);
            if (c >= LAT) begin
                chk("bp_hold_valid", 64'(out_valid), 64'h1);
                chk("bp_hold_data", 64'(out_data), 64'h3);
            end
            take = in_valid & in_ready;
            @(posedge clk);
            if (take) acc++;
        end
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (acc < 3);
            if (acc < 3) in_data = wq[acc];
            #1;
            take = in_valid & in_ready;
            if (out_valid) got.push_back(out_data);
            @(posedge clk);
            if (take) acc++;
        end
        #1;
        in_valid = 1'b0;
        chk("bp_count", 64'(got.size()), 64'h3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("bp_order", 64'(got[i]), 64'(wq[i]));
        chk("bp_db_cnt", 64'(db_cnt), 64'h3);

        // async reset during a stall
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20; in_ecc = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("stall_valid", 64'(out_valid), 64'h1);
        chk("stall_sb_cnt", 64'(sb_cnt), 64'h1);
        rst_l = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_sb_cnt", 64'(sb_cnt), 64'h0);
        chk("arst_db_cnt", 64'(db_cnt), 64'h0);
        chk("arst_log", 64'(log_valid), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk); rst_l = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rvecc_pipe.md
# rvecc_pipe

Parametrised, pipelined SECDED check/correct stage for memory read paths (DCCM, ICCM, I$ data) with a valid/ready handshake. It supports arbitrary data width, saturating error counters and a sticky first-error log. It sits between an SRAM read port and its consumer, and replaces the purely combinational single-width decoder where timing or observability is required.

## Interface
- DW, 32: data width, 8..64.
- CNT_W, 16: error-counter width, >= 2.
- Derived, not a port: P = smallest integer with 2^P >= DW+P+1. EW = P+1 (7 for DW=32, 8 for DW=64).
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept the input word.
- in_data  in  DW  raw data.
- in_ecc  in  EW  stored check bits; [EW-1] is overall parity.
- in_sed_ded  in  1  detect only, no correction (I$ mode).
- out_valid  out  1  corrected word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DW  corrected data.
- out_ecc  out  EW  corrected check bits.
- out_sb_err  out  1  single error detected and corrected.
- out_db_err  out  1  uncorrectable error.
- sb_cnt  out  CNT_W  saturating single-error count.
- db_cnt  out  CNT_W  saturating double-error count.
- cnt_clr  in  1  synchronous clear of both counters.
- log_valid  out  1  sticky: error log holds a capture.
- log_syndrome  out  EW  captured syndrome.
- log_data  out  DW  captured raw (uncorrected) data.
- log_clr  in  1  clears log_valid.

## Operation
- Code layout: Hamming positions 1..DW+P.
  - Check bit k sits at position 2^k.
  - Data bits fill the non-power-of-two positions in ascending order (d0 at position 3).
  - ecc[EW-1] is even parity over all data and check bits.
- Syndrome:
  - s[P-1:0] = XOR of the check bits recomputed from data with in_ecc[P-1:0].
  - s[EW-1] = overall parity mismatch, forced to 0 when in_sed_ded=1.
- Classification, given s != 0:
  - s[EW-1]=1 gives a single error (sb). Flip the position s[P-1:0]. If s[P-1:0]=0, only the overall parity bit is flipped.
  - s[EW-1]=0 gives a double error (db). Data and ecc pass through unmodified.
  - With in_sed_ded=1, every error is reported db and nothing is corrected.
- A syndrome position greater than DW+P with s[EW-1]=1 is reported db and nothing is corrected.
- Counters:
  - Increment on the output handshake (out_valid & out_ready) when the err flag is set.
  - Saturate at all-ones.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Error log:
  - Captures on the first erroring handshake while log_valid=0.
  - A db handshake also overwrites a logged sb (severity upgrade).
  - A later error of the same or lower severity does not overwrite.
  - log_clr together with an erroring handshake: the new error is captured and log_valid stays 1.

## Timing
- Reset values: in_ready=1 and every other output 0, including counters, log and pipeline valids.
- Reset mid-operation discards all in-flight words.
- Pipeline stage S1 registers in_data, in_ecc, in_sed_ded and the syndrome. Stage S2 registers the corrected data and flags.
- Latency: accept in cycle N gives out_valid in cycle N+2.
- Throughput: one word per cycle.
- Handshake:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv, a combinational path from out_ready.
- While out_valid=1 and out_ready=0, every out_* signal stays stable.
- Two words can be buffered; in_ready falls only when both stages are full and out_ready=0.
- Counters and log update in the cycle after the handshake.

## Configuration
- Macro: RV_ECC_PIPE_DUAL_STAGE_EN.
- Defined: two register stages as above; latency 2, buffering 2.
- Undefined:
  - S1 only; correction is combinational from the S1 registers.
  - Latency 1, buffering 1.
  - in_ready = ~s1_v | out_ready.
  - Counter and log rules are unchanged.

## Test plan
- Clean word, DW=32, data 32'h0000_0000, ecc 7'h00: out_data 0, both err flags 0, counters unchanged, out_valid exactly 2 cycles after accept.
- Single error, data bit d5 flipped (in_data 32'h20, ecc 7'h00): syndrome 7'h4A, out_data 0, out_sb_err=1, sb_cnt=1, log_valid=1, log_syndrome 7'h4A, log_data 32'h20.
- Double error, in_data 32'h3 with ecc 0: out_db_err=1 and out_data 32'h3. Log upgrades from the earlier sb; the same-cycle log_clr case keeps log_valid=1.
- sed_ded mode, single flip with in_sed_ded=1: out_db_err=1, out_sb_err=0, data not corrected.
- Saturation, CNT_W=2, five sb words: sb_cnt stops at 3. cnt_clr asserted with a sixth sb word gives sb_cnt=0.
- Backpressure, back-to-back words A, B, C with out_ready low for 4 cycles:
  - in_ready falls while C is presented.
  - A is held stable.
  - Words emerge in order A, B, C with no loss.
  - rst_l low mid-stall clears out_valid and the counters asynchronously.
